// File: rtl/kb_pkg.sv
// Shared constants and the PS/2 set-2 scan-code to ASCII table for the keyboard interface.
package kb_pkg;

    localparam int FIFO_DEPTH = 16;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXTEND = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    typedef struct packed {
        logic       valid;
        logic [6:0] ascii;
    } kb_char_t;

    // Returns valid=0 for codes with no printable/control mapping.
    function automatic kb_char_t scan_to_ascii(input logic [7:0] code, input logic shift);
        kb_char_t   res;
        logic [6:0] plain;
        logic [6:0] shifted;
        logic       hit;
        hit = 1'b1;
        case (code)
            8'h1C: begin plain = 7'h61; shifted = 7'h41; end
            8'h32: begin plain = 7'h62; shifted = 7'h42; end
            8'h21: begin plain = 7'h63; shifted = 7'h43; end
            8'h23: begin plain = 7'h64; shifted = 7'h44; end
            8'h24: begin plain = 7'h65; shifted = 7'h45; end
            8'h2B: begin plain = 7'h66; shifted = 7'h46; end
            8'h34: begin plain = 7'h67; shifted = 7'h47; end
            8'h33: begin plain = 7'h68; shifted = 7'h48; end
            8'h43: begin plain = 7'h69; shifted = 7'h49; end
            8'h3B: begin plain = 7'h6A; shifted = 7'h4A; end
            8'h42: begin plain = 7'h6B; shifted = 7'h4B; end
            8'h4B: begin plain = 7'h6C; shifted = 7'h4C; end
            8'h3A: begin plain = 7'h6D; shifted = 7'h4D; end
            8'h31: begin plain = 7'h6E; shifted = 7'h4E; end
            8'h44: begin plain = 7'h6F; shifted = 7'h4F; end
            8'h4D: begin plain = 7'h70; shifted = 7'h50; end
            8'h15: begin plain = 7'h71; shifted = 7'h51; end
            8'h2D: begin plain = 7'h72; shifted = 7'h52; end
            8'h1B: begin plain = 7'h73; shifted = 7'h53; end
            8'h2C: begin plain = 7'h74; shifted = 7'h54; end
            8'h3C: begin plain = 7'h75; shifted = 7'h55; end
            8'h2A: begin plain = 7'h76; shifted = 7'h56; end
            8'h1D: begin plain = 7'h77; shifted = 7'h57; end
            8'h22: begin plain = 7'h78; shifted = 7'h58; end
            8'h35: begin plain = 7'h79; shifted = 7'h59; end
            8'h1A: begin plain = 7'h7A; shifted = 7'h5A; end
            8'h45: begin plain = 7'h30; shifted = 7'h29; end
            8'h16: begin plain = 7'h31; shifted = 7'h21; end
            8'h1E: begin plain = 7'h32; shifted = 7'h40; end
            8'h26: begin plain = 7'h33; shifted = 7'h23; end
            8'h25: begin plain = 7'h34; shifted = 7'h24; end
            8'h2E: begin plain = 7'h35; shifted = 7'h25; end
            8'h36: begin plain = 7'h36; shifted = 7'h5E; end
            8'h3D: begin plain = 7'h37; shifted = 7'h26; end
            8'h3E: begin plain = 7'h38; shifted = 7'h2A; end
            8'h46: begin plain = 7'h39; shifted = 7'h28; end
            8'h29: begin plain = 7'h20; shifted = 7'h20; end
            8'h5A: begin plain = 7'h0D; shifted = 7'h0D; end
            8'h66: begin plain = 7'h08; shifted = 7'h08; end
            default: begin plain = 7'h00; shifted = 7'h00; hit = 1'b0; end
        endcase
        res.valid = hit;
        res.ascii = shift ? shifted : plain;
        return res;
    endfunction

endpackage

// File: rtl/kb_fifo.sv
// First-word-fall-through character buffer with occupancy count.
module kb_fifo
    import kb_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int WIDTH = 7,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Accept a pop only with data present; a push into a full buffer needs a same-cycle pop.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Pointer and count registers; clear wins over any push/pop in the same cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never cleared; stale entries are unreachable once count is zero.
    always_ff @(posedge clk) begin
        if (!clr) begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/keyboard_interface_top.sv
// PS/2 set-2 decoder: tracks break/extended/shift prefixes and buffers translated ASCII.
module keyboard_interface_top
    import kb_pkg::*;
#(
    parameter int FIFO_DEPTH = kb_pkg::FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       KB_clear,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       KB_read_en,
    output logic       KB_status,
    output logic [6:0] KB_data,
    output logic       buf_full
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic       break_q, break_d;
    logic       ext_q, ext_d;
    logic       shift_q, shift_d;
    logic       push;
    logic       is_shift_code;
    kb_char_t   xlat;

    logic [6:0] fifo_dout;
    logic [AW:0] fifo_count;
    logic       fifo_full;
    logic       fifo_empty;

    // Decode one byte per strobe; prefixes arm flags, the following byte resolves and clears them.
    always_comb begin
        break_d       = break_q;
        ext_d         = ext_q;
        shift_d       = shift_q;
        push          = 1'b0;
        is_shift_code = (rx_data == SC_LSHIFT) || (rx_data == SC_RSHIFT);
        xlat          = scan_to_ascii(rx_data, shift_q);
        if (rx_done) begin
            if (rx_data == SC_BREAK) begin
                break_d = 1'b1;
            end else if (rx_data == SC_EXTEND) begin
                ext_d = 1'b1;
            end else begin
                break_d = 1'b0;
                ext_d   = 1'b0;
                // Extended codes are discarded outright, including E0-prefixed shift codes.
                if (!ext_q && is_shift_code) begin
                    shift_d = !break_q;
                end else if (!ext_q && !break_q && xlat.valid) begin
                    push = 1'b1;
                end
            end
        end
    end

    // Decoder flag registers.
    always_ff @(posedge clk) begin
        if (KB_clear) begin
            break_q <= 1'b0;
            ext_q   <= 1'b0;
            shift_q <= 1'b0;
        end else begin
            break_q <= break_d;
            ext_q   <= ext_d;
            shift_q <= shift_d;
        end
    end

    kb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (7)
    ) u_fifo (
        .clk   (clk),
        .clr   (KB_clear),
        .push  (push),
        .din   (xlat.ascii),
        .pop   (KB_read_en),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign KB_status = (fifo_count != '0);
    assign buf_full  = fifo_full;
    assign KB_data   = fifo_empty ? 7'h00 : fifo_dout;

endmodule

// File: tb/tb_keyboard_interface_top.sv
// Directed plus randomized bench for keyboard_interface_top against a queue-based reference.
module tb_keyboard_interface_top;

    logic       clk = 1'b0;
    logic       KB_clear = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       KB_read_en = 1'b0;
    logic       KB_status;
    logic [6:0] KB_data;
    logic       buf_full;

    int n_cmp = 0;
    int n_err = 0;

    keyboard_interface_top #(.FIFO_DEPTH(16)) dut (
        .clk        (clk),
        .KB_clear   (KB_clear),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .KB_read_en (KB_read_en),
        .KB_status  (KB_status),
        .KB_data    (KB_data),
        .buf_full   (buf_full)
    );

    always #5 clk = ~clk;

    // Reference model state: buffered characters and pending-prefix / modifier knowledge.
    int q[$];
    bit m_release;
    bit m_extended;
    bit m_shift;

    string      letters   = "abcdefghijklmnopqrstuvwxyz";
    string      shifted_d = ")!@#$%^&*(";
    logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                   8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                   8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                   8'h35, 8'h1A};
    logic [7:0] digit_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                  8'h3E, 8'h46};
    logic [7:0] pool [16] = '{8'hF0, 8'hE0, 8'h12, 8'h59, 8'h1C, 8'h16, 8'h45, 8'h29,
                              8'h5A, 8'h66, 8'h1B, 8'h3A, 8'h75, 8'h1A, 8'h46, 8'h00};

    function automatic bit lookup(input logic [7:0] code, input bit shift, output int ch);
        ch = 0;
        for (int i = 0; i < 26; i++)
            if (letter_sc[i] == code) begin
                ch = int'(letters[i]) - (shift ? 32 : 0);
                return 1'b1;
            end
        for (int i = 0; i < 10; i++)
            if (digit_sc[i] == code) begin
                ch = shift ? int'(shifted_d[i]) : 48 + i;
                return 1'b1;
            end
        if (code == 8'h29) begin ch = 32; return 1'b1; end
        if (code == 8'h5A) begin ch = 13; return 1'b1; end
        if (code == 8'h66) begin ch = 8;  return 1'b1; end
        return 1'b0;
    endfunction

    task automatic model_edge(input bit clr, input bit rd, input bit done, input logic [7:0] data);
        int ch;
        bit have;
        bit is_shift;
        have = 1'b0;
        if (clr) begin
            q.delete();
            m_release  = 0;
            m_extended = 0;
            m_shift    = 0;
            return;
        end
        if (done) begin
            is_shift = (data == 8'h12) || (data == 8'h59);
            if (data == 8'hF0) m_release = 1;
            else if (data == 8'hE0) m_extended = 1;
            else begin
                if (m_extended) begin
                    // discarded
                end else if (m_release) begin
                    if (is_shift) m_shift = 0;
                end else if (is_shift) begin
                    m_shift = 1;
                end else begin
                    have = lookup(data, m_shift, ch);
                end
                m_release  = 0;
                m_extended = 0;
            end
        end
        if (rd && q.size() > 0) void'(q.pop_front());
        if (have && q.size() < 16) q.push_back(ch);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_status"}, {7'b0, KB_status}, {7'b0, q.size() != 0});
        check({tag, "_full"},   {7'b0, buf_full},  {7'b0, q.size() == 16});
        check({tag, "_data"},   {1'b0, KB_data},   (q.size() != 0) ? 8'(q[0]) : 8'h00);
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge.
    task automatic cyc(input string tag, input bit clr, input bit rd, input bit done,
                       input logic [7:0] data);
        KB_clear   = clr;
        KB_read_en = rd;
        rx_done    = done;
        rx_data    = data;
        @(posedge clk);
        model_edge(clr, rd, done, data);
        @(negedge clk);
        KB_clear   = 1'b0;
        KB_read_en = 1'b0;
        rx_done    = 1'b0;
        check_outputs(tag);
    endtask

    task automatic strobe(input string tag, input logic [7:0] data);
        cyc(tag, 1'b0, 1'b0, 1'b1, data);
    endtask

    task automatic pop(input string tag);
        cyc(tag, 1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        int last_read;
        @(negedge clk);

        // Reset, then idle with a break code on the bus but no strobe.
        cyc("reset", 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) cyc("idle", 1'b0, 1'b0, 1'b0, (i == 2) ? 8'hF0 : 8'h00);
        check("reset_data_lit", {1'b0, KB_data}, 8'h00);

        // Make then break of 'a'.
        strobe("mb_make", 8'h1C);
        check("mb_first_lit", {1'b0, KB_data}, 8'h61);
        strobe("mb_f0", 8'hF0);
        strobe("mb_brk", 8'h1C);
        pop("mb_pop");
        check("mb_empty_lit", {7'b0, KB_status}, 8'h00);

        // Shifted and unshifted 'a'.
        strobe("sh_make", 8'h12);
        strobe("sh_a", 8'h1C);
        strobe("sh_f0", 8'hF0);
        strobe("sh_brk", 8'h12);
        strobe("sh_a2", 8'h1C);
        check("sh_head_lit", {1'b0, KB_data}, 8'h41);
        pop("sh_pop1");
        check("sh_next_lit", {1'b0, KB_data}, 8'h61);
        pop("sh_pop2");

        // Overfill with '1'.
        for (int i = 0; i < 17; i++) strobe("full_push", 8'h16);
        check("full_lit", {7'b0, buf_full}, 8'h01);
        for (int i = 0; i < 16; i++) pop("full_pop");
        pop("full_pop_empty");

        // Full buffer with simultaneous push of '0' and pop.
        for (int i = 0; i < 16; i++) strobe("sim_fill", 8'h16);
        cyc("sim_both", 1'b0, 1'b1, 1'b1, 8'h45);
        check("sim_full_lit", {7'b0, buf_full}, 8'h01);
        last_read = 0;
        for (int i = 0; i < 16; i++) begin
            last_read = KB_data;
            pop("sim_pop");
        end
        check("sim_last_lit", 8'(last_read), 8'h30);

        // Reset mid-sequence, with clear competing against strobe and read.
        strobe("mid_f0", 8'hF0);
        cyc("mid_clr", 1'b1, 1'b1, 1'b1, 8'h1C);
        strobe("mid_a", 8'h1C);
        check("mid_a_lit", {1'b0, KB_data}, 8'h61);
        strobe("ext_e0", 8'hE0);
        strobe("ext_75", 8'h75);
        strobe("ext_e0b", 8'hE0);
        strobe("ext_f0", 8'hF0);
        strobe("ext_brk", 8'h75);
        strobe("unmapped", 8'h76);
        pop("mid_pop");

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            logic [7:0] d;
            d = ($urandom_range(0, 9) < 3) ? 8'($urandom) : pool[$urandom_range(0, 15)];
            cyc("rand", $urandom_range(0, 149) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 1) == 1, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
